pll_clk_div: RTL and testbench

- Digital stand-in for the vendor clock PLL used at the top of the VGA display path.
- Derives c0 from inclk0 by integer division (default 50 MHz -> 25 MHz pixel clock).
- Raises locked once c0 has run a fixed number of clean periods after reset.
- Purely synchronous to inclk0; no analog blocks and no vendor primitives.

---
 rtl/clk_pkg.sv | 28 ++
 rtl/pll_clk_div_rst_sync.sv | 29 ++
 rtl/pll_clk_div.sv | 101 ++++++++++
 tb/tb_pll_clk_div.sv | 110 +++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// ---------------------------------------------------------------------------
// clk_pkg : shared defaults and helper for the pll_clk_div clock stand-in
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clk_pkg;

  localparam int DEF_DIV_RATIO   = 2;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage : clk_pkg

`default_nettype wire

// File: rtl/pll_clk_div_rst_sync.sv
// ---------------------------------------------------------------------------
// rst_sync : async-assert / sync-deassert active-low reset synchronizer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_no = sync_q[STAGES-1];

endmodule : rst_sync

`default_nettype wire

// File: rtl/pll_clk_div.sv
// ---------------------------------------------------------------------------
// pll_clk_div : digital PLL stand-in, integer clock divider with lock flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pll_clk_div
  import clk_pkg::*;
#(
  parameter int DIV_RATIO   = DEF_DIV_RATIO,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic inclk0,
  input  logic areset,
  output logic c0,
  output logic locked
);

  localparam int CW = clog2(DIV_RATIO);
  localparam int LW = clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV_RATIO - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'((DIV_RATIO + 1) / 2);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

  generate
    if (DIV_RATIO < 2 || DIV_RATIO > 256) begin : g_bad_div
      $error("pll_clk_div: DIV_RATIO must be in 2..256");
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
      $error("pll_clk_div: LOCK_CYCLES must be in 1..65535");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("pll_clk_div: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  logic run_en;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk_i  (inclk0),
    .rst_ni (areset),
    .rst_no (run_en)
  );

  logic          started_q, started_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          c0_q,      c0_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q,  locked_d;
  logic          wrap;

  // The first run edge only primes the divider so c0 rises one cycle after release.
  always_comb begin
    started_d  = started_q;
    cnt_d      = cnt_q;
    c0_d       = c0_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    wrap       = 1'b0;
    if (run_en) begin
      if (!started_q) begin
        started_d = 1'b1;
        cnt_d     = '0;
        c0_d      = 1'b1;
      end else begin
        wrap  = (cnt_q == CNT_MAX);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        c0_d  = (cnt_d < CNT_HIGH);
        if (wrap && lock_cnt_q != LOCK_MAX) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
        locked_d = locked_q | (lock_cnt_d == LOCK_MAX);
      end
    end
  end

  always_ff @(posedge inclk0 or negedge areset) begin
    if (!areset) begin
      started_q  <= 1'b0;
      cnt_q      <= '0;
      c0_q       <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      started_q  <= started_d;
      cnt_q      <= cnt_d;
      c0_q       <= c0_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign c0     = c0_q;
  assign locked = locked_q;

endmodule : pll_clk_div

`default_nettype wire

// File: tb/tb_pll_clk_div.sv
// ---------------------------------------------------------------------------
// tb_pll_clk_div : directed self-checking bench for pll_clk_div
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pll_clk_div;

  logic inclk0;
  logic areset;
  logic c0_a, locked_a;   // DIV 2, LOCK 16
  logic c0_b, locked_b;   // DIV 5, LOCK 16
  logic c0_c, locked_c;   // DIV 4, LOCK 1

  int n_checks;
  int n_errors;

  pll_clk_div #(.DIV_RATIO(2), .LOCK_CYCLES(16), .SYNC_STAGES(2)) dut_a (
    .inclk0 (inclk0), .areset (areset), .c0 (c0_a), .locked (locked_a)
  );
  pll_clk_div #(.DIV_RATIO(5), .LOCK_CYCLES(16), .SYNC_STAGES(2)) dut_b (
    .inclk0 (inclk0), .areset (areset), .c0 (c0_b), .locked (locked_b)
  );
  pll_clk_div #(.DIV_RATIO(4), .LOCK_CYCLES(1), .SYNC_STAGES(2)) dut_c (
    .inclk0 (inclk0), .areset (areset), .c0 (c0_c), .locked (locked_c)
  );

  initial inclk0 = 1'b0;
  always #10 inclk0 = ~inclk0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge inclk0);
    #1;
  endtask

  function automatic logic exp_c0(input int n, input int div);
    if (n < 3) return 1'b0;
    return ((n - 3) % div) < ((div + 1) / 2);
  endfunction

  function automatic logic exp_lock(input int n, input int div, input int lc);
    return n >= 3 + div * lc;
  endfunction

  function automatic logic [5:0] observed();
    return {c0_a, locked_a, c0_b, locked_b, c0_c, locked_c};
  endfunction

  // Edge n counts inclk0 rising edges since areset went high.
  task automatic run_seq(input int nmax, output int rises_a);
    logic       prev;
    logic [5:0] exp;
    rises_a = 0;
    prev    = c0_a;
    for (int n = 1; n <= nmax; n++) begin
      tick();
      exp = {exp_c0(n, 2), exp_lock(n, 2, 16),
             exp_c0(n, 5), exp_lock(n, 5, 16),
             exp_c0(n, 4), exp_lock(n, 4, 1)};
      check($sformatf("seq n=%0d", n), 32'(observed()), 32'(exp));
      if (c0_a && !prev) rises_a++;
      prev = c0_a;
    end
  endtask

  initial begin
    int rises;
    n_checks = 0;
    n_errors = 0;
    areset   = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("reset_hold %0d", i), 32'(observed()), 32'h0);
    end

    @(negedge inclk0);
    areset = 1'b1;
    run_seq(1100, rises);
    // DIV 2 rises on edges 3,5,...,1099
    check("rise_count", 32'(rises), 32'd549);

    tick();
    check("pre_pulse", 32'(observed()), 32'b11_0101);

    #5;
    areset = 1'b0;
    #2;
    check("pulse_clear", 32'(observed()), 32'h0);
    #4;
    areset = 1'b1;

    run_seq(100, rises);
    check("rise_count_restart", 32'(rises), 32'd49);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pll_clk_div

`default_nettype wire
